// File: rtl/rand_range_gen.sv
// rand_range_gen -- constrained-random value source.
//
// Produces pseudo-random values in the inclusive range [lo_i, hi_i] by
// drawing candidates from a Galois LFSR and rejecting out-of-range ones.
// If MAX_TRIES candidates miss, lo_q is emitted instead and the fallback
// counter is bumped, so every request completes in bounded time.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         synchronous active-low reset
//   en_i           request generation
//   lo_i, hi_i     inclusive bounds, latched when a search starts
//   seed_load_i    load seed_i (or SEED when seed_i is zero) into the LFSR
//   seed_i         seed value
//   rnd_valid_o    rnd_data_o holds a value
//   rnd_ready_i    consumer accepts
//   rnd_data_o     generated value
//   cfg_err_o      registered en_i && (lo_i > hi_i)
//   fallback_cnt_o saturating count of fallbacks
//   dbg_state_o    current FSM state (0 IDLE, 1 SEARCH, 2 HOLD)
//
// Output handshake: a value transfers on a rising edge where rnd_valid_o
// and rnd_ready_i are both high. Once rnd_valid_o rises, rnd_data_o stays
// stable and rnd_valid_o stays high until that transfer; rnd_valid_o never
// depends combinationally on rnd_ready_i.

module rand_range_gen #(
  parameter int                WIDTH     = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 8,
  parameter int                CNT_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [WIDTH-1:0]  lo_i,
  input  logic [WIDTH-1:0]  hi_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              rnd_valid_o,
  input  logic              rnd_ready_i,
  output logic [WIDTH-1:0]  rnd_data_o,
  output logic              cfg_err_o,
  output logic [CNT_W-1:0]  fallback_cnt_o,
  output logic [1:0]        dbg_state_o
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [TRY_W-1:0]   try_cnt_q, try_cnt_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   fb_cnt_q, fb_cnt_d;
  logic               cfg_err_q;

  logic [WIDTH-1:0]   cand;
  logic [LFSR_W-1:0]  lfsr_step;
  logic               req_ok;

  // Candidate is taken from the register before this cycle's step.
  assign cand      = lfsr_q[WIDTH-1:0];
  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  assign req_ok    = en_i && (lo_i <= hi_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      try_cnt_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      fb_cnt_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      try_cnt_q <= try_cnt_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      fb_cnt_q  <= fb_cnt_d;
      cfg_err_q <= en_i && (lo_i > hi_i);
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    try_cnt_d = try_cnt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    valid_d   = valid_q;
    data_d    = data_q;
    fb_cnt_d  = fb_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_ok) begin
          lo_d      = lo_i;
          hi_d      = hi_i;
          try_cnt_d = '0;
          state_d   = SEARCH;
        end
      end

      SEARCH: begin
        lfsr_d = lfsr_step;
        if ((cand >= lo_q) && (cand <= hi_q)) begin
          data_d  = cand;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (try_cnt_q == LAST_TRY) begin
          data_d  = lo_q;
          valid_d = 1'b1;
          if (fb_cnt_q != '1) fb_cnt_d = fb_cnt_q + 1'b1;
          state_d = HOLD;
        end else begin
          try_cnt_d = try_cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (rnd_ready_i) begin
          valid_d = 1'b0;
          if (req_ok) begin
            lo_d      = lo_i;
            hi_d      = hi_i;
            try_cnt_d = '0;
            state_d   = SEARCH;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // A seed load replaces any step this cycle; the FSM is unaffected.
    // A zero seed would lock the LFSR, so SEED is substituted.
    if (seed_load_i) lfsr_d = (seed_i == '0) ? SEED : seed_i;
  end

  assign rnd_valid_o    = valid_q;
  assign rnd_data_o     = data_q;
  assign cfg_err_o      = cfg_err_q;
  assign fallback_cnt_o = fb_cnt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rand_range_gen.sv
module tb_rand_range_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  lo;
  logic [7:0]  hi;
  logic        seed_load;
  logic [15:0] seed;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [7:0]  rnd_data;
  logic        cfg_err;
  logic [7:0]  fallback_cnt;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  rand_range_gen dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .lo_i           (lo),
    .hi_i           (hi),
    .seed_load_i    (seed_load),
    .seed_i         (seed),
    .rnd_valid_o    (rnd_valid),
    .rnd_ready_i    (rnd_ready),
    .rnd_data_o     (rnd_data),
    .cfg_err_o      (cfg_err),
    .fallback_cnt_o (fallback_cnt),
    .dbg_state_o    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en = 1'b0; lo = '0; hi = '0;
    seed_load = 1'b0; seed = '0; rnd_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (rnd_valid !== 1'b0 || rnd_data !== 8'd0 || cfg_err !== 1'b0 ||
        fallback_cnt !== 8'd0 || dbg_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL reset: valid=%0b data=%0d err=%0b fb=%0d st=%0d, need all 0",
               rnd_valid, rnd_data, cfg_err, fallback_cnt, dbg_state);
    end
  endtask

  // Full range, ready high: one value every two cycles.
  task automatic test_full_range();
    logic [7:0] exp_seq [4] = '{8'd225, 8'd112, 8'd56, 8'd156};
    apply_reset();
    lo = 8'd0; hi = 8'd255; rnd_ready = 1'b1; en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (rnd_valid !== 1'b1 || rnd_data !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL full_range[%0d]: valid=%0b data=%0d, need valid=1 data=%0d",
                 i, rnd_valid, rnd_data, exp_seq[i]);
      end
      tick();
      tests_run++;
      if (rnd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL full_range_gap[%0d]: valid=%0b, need 0", i, rnd_valid);
      end
    end
    tests_run++;
    if (fallback_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL full_range_fb: fb=%0d, need 0", fallback_cnt);
    end
    en = 1'b0;
  endtask

  // Narrow range; bounds changed mid-search must be ignored.
  task automatic test_narrow();
    apply_reset();
    lo = 8'd50; hi = 8'd60; rnd_ready = 1'b1; en = 1'b1;
    tick();
    lo = 8'd0; hi = 8'd255;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (rnd_valid !== 1'b0 || dbg_state !== S_SEARCH) begin
        tests_failed++;
        $display("FAIL narrow_reject[%0d]: valid=%0b st=%0d, need valid=0 st=1",
                 i, rnd_valid, dbg_state);
      end
    end
    tick();
    tests_run++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'd56) begin
      tests_failed++;
      $display("FAIL narrow_accept: valid=%0b data=%0d, need valid=1 data=56",
               rnd_valid, rnd_data);
    end
    en = 1'b0;
    tick();
    tests_run++;
    if (dbg_state !== S_IDLE || rnd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL narrow_idle: st=%0d valid=%0b, need st=0 valid=0",
               dbg_state, rnd_valid);
    end
  endtask

  // lo==hi==1: eight misses, fallback; then reset while searching.
  task automatic test_fallback_and_reset();
    apply_reset();
    lo = 8'd1; hi = 8'd1; rnd_ready = 1'b0; en = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      tests_run++;
      if (rnd_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL fallback_early[%0d]: valid=%0b, need 0", i, rnd_valid);
      end
    end
    tick();
    tests_run++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'd1 || fallback_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL fallback: valid=%0b data=%0d fb=%0d, need 1/1/1",
               rnd_valid, rnd_data, fallback_cnt);
    end
    rnd_ready = 1'b1;
    tick();
    tests_run++;
    if (dbg_state !== S_SEARCH || rnd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fallback_restart: st=%0d valid=%0b, need st=1 valid=0",
               dbg_state, rnd_valid);
    end
    rst_n = 1'b0; lo = 8'd10; hi = 8'd5;
    tick();
    tests_run++;
    if (rnd_valid !== 1'b0 || rnd_data !== 8'd0 || cfg_err !== 1'b0 ||
        fallback_cnt !== 8'd0 || dbg_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL reset_in_search: valid=%0b data=%0d err=%0b fb=%0d st=%0d, need all 0",
               rnd_valid, rnd_data, cfg_err, fallback_cnt, dbg_state);
    end
    rst_n = 1'b1; en = 1'b0;
  endtask

  // lo>hi: error flag, no search, LFSR untouched.
  task automatic test_cfg_err();
    apply_reset();
    lo = 8'd10; hi = 8'd5; rnd_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (cfg_err !== 1'b1 || rnd_valid !== 1'b0 || dbg_state !== S_IDLE) begin
        tests_failed++;
        $display("FAIL cfg_err[%0d]: err=%0b valid=%0b st=%0d, need 1/0/0",
                 i, cfg_err, rnd_valid, dbg_state);
      end
    end
    lo = 8'd0; hi = 8'd255;
    tick();
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL cfg_err_clear: err=%0b, need 0", cfg_err);
    end
    tick();
    tests_run++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'd225) begin
      tests_failed++;
      $display("FAIL cfg_err_lfsr: valid=%0b data=%0d, need valid=1 data=225",
               rnd_valid, rnd_data);
    end
    en = 1'b0;
  endtask

  // Backpressure holds the value and freezes the LFSR; then a zero-seed load.
  task automatic test_hold_and_seed();
    apply_reset();
    lo = 8'd0; hi = 8'd255; rnd_ready = 1'b0; en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (rnd_valid !== 1'b1 || rnd_data !== 8'd225 || dbg_state !== S_HOLD) begin
        tests_failed++;
        $display("FAIL hold[%0d]: valid=%0b data=%0d st=%0d, need 1/225/2",
                 i, rnd_valid, rnd_data, dbg_state);
      end
    end
    rnd_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'd112) begin
      tests_failed++;
      $display("FAIL hold_release: valid=%0b data=%0d, need valid=1 data=112",
               rnd_valid, rnd_data);
    end
    rnd_ready = 1'b0; seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    tests_run++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'd112 || dbg_state !== S_HOLD) begin
      tests_failed++;
      $display("FAIL seed_hold: valid=%0b data=%0d st=%0d, need 1/112/2",
               rnd_valid, rnd_data, dbg_state);
    end
    rnd_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'd225) begin
      tests_failed++;
      $display("FAIL seed_zero: valid=%0b data=%0d, need valid=1 data=225",
               rnd_valid, rnd_data);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_range();
    test_narrow();
    test_fallback_and_reset();
    test_cfg_err();
    test_hold_and_seed();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rand_range_gen.md
Name: rand_range_gen

Overview:
- Parametrised, clocked successor to the combinational random-stimulus block.
- Generates pseudo-random values restricted to a runtime range [lo_i, hi_i].
- Uses a Galois LFSR with rejection sampling, a bounded retry count, a fallback value, and a valid/ready output stream.
- Used on-chip as a constrained-random stimulus source for self-checking designs.

Parameters:
- WIDTH, 8, output value width; must be <= LFSR_W.
- LFSR_W, 16, LFSR register width.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1, reset seed; also replaces any zero seed load.
- MAX_TRIES, 8, candidates tested before fallback; must be >= 1.
- CNT_W, 8, width of the fallback counter.

Ports:
- clk_i, input, 1, clock; all logic on the rising edge.
- rst_ni, input, 1, synchronous active-low reset.
- en_i, input, 1, request generation.
- lo_i, input, WIDTH, inclusive lower bound.
- hi_i, input, WIDTH, inclusive upper bound.
- seed_load_i, input, 1, load seed_i into the LFSR.
- seed_i, input, LFSR_W, seed value.
- rnd_valid_o, output, 1, rnd_data_o holds a value.
- rnd_ready_i, input, 1, consumer accepts.
- rnd_data_o, output, WIDTH, generated value.
- cfg_err_o, output, 1, registered flag: en_i high with lo_i > hi_i.
- fallback_cnt_o, output, CNT_W, saturating count of fallbacks.

Behaviour:
- Reset: a synchronous reset (rst_ni low at an edge) sets:
  - lfsr = SEED, state = IDLE, try_cnt = 0;
  - rnd_valid_o = 0, rnd_data_o = 0, cfg_err_o = 0, fallback_cnt_o = 0.
  - Reset wins over every other input, in any state.
- LFSR:
  - Steps once per cycle, only in SEARCH: next = lsb ? (lfsr>>1)^TAPS : lfsr>>1.
  - Candidate = lfsr[WIDTH-1:0], taken before the step.
  - seed_load_i=1 loads seed_i, or SEED if seed_i==0. The load overrides the step that cycle and does not change state.
- cfg_err_o: registered every cycle as en_i && (lo_i > hi_i).
- IDLE:
  - en_i=1 and lo_i<=hi_i: latch lo_i/hi_i into lo_q/hi_q, try_cnt=0, go to SEARCH.
  - Otherwise stay in IDLE.
- SEARCH, one candidate per cycle, compared against the latched bounds:
  - lo_q <= cand <= hi_q: rnd_data_o = cand, rnd_valid_o = 1, go to HOLD.
  - Else, if try_cnt == MAX_TRIES-1: rnd_data_o = lo_q, rnd_valid_o = 1, fallback_cnt_o += 1 (saturates at all-ones), go to HOLD.
  - Else: try_cnt += 1.
  - Changes to lo_i/hi_i during SEARCH have no effect; en_i falling during SEARCH does not abort it.
- HOLD:
  - rnd_valid_o and rnd_data_o stay stable and the LFSR is frozen until rnd_ready_i=1.
  - On handshake: rnd_valid_o = 0.
    - If en_i=1 and lo_i<=hi_i: relatch the bounds, try_cnt=0, go to SEARCH.
    - Otherwise go to IDLE.
- Latency:
  - en_i sampled high at edge N puts the block in SEARCH.
  - First candidate accepted: rnd_valid_o high after edge N+1.
  - k-th candidate accepted: high after edge N+k.
  - Worst case: edge N+MAX_TRIES.
- Throughput: with rnd_ready_i held high and first-try acceptance, one value every 2 cycles.
- Boundaries:
  - lo==hi: legal; exact match or fallback.
  - lo=0, hi=2^WIDTH-1: always first-try accept.
  - lo>hi: cfg_err_o=1, no SEARCH entry, no output.

Test Plan:
- Defaults, en_i=1, lo=0, hi=255, ready=1 -> rnd_data_o sequence 225, 112, 56, 156; fallback_cnt_o=0; valid high for 1 cycle every 2 cycles.
- Fresh reset, lo=50, hi=60 -> candidates 225, 112, 56; rnd_data_o=56 after 3 SEARCH cycles.
- Fresh reset, lo=hi=1 -> first 8 candidates (E1, 70, 38, 9C, 4E, 27, 13, 89) all rejected; rnd_data_o=1, fallback_cnt_o=1, valid at SEARCH cycle 8.
- Fresh reset, lo=10, hi=5, en=1 -> cfg_err_o=1 from the next cycle; rnd_valid_o stays 0; LFSR stays 0xACE1 (checked by then setting lo=0, hi=255 -> first output 225).
- Full range, ready=0 for 5 cycles after the first valid -> rnd_data_o=225 held stable. Raise ready -> next value 112 (LFSR frozen during HOLD).
- Two checks:
  - seed_load_i with seed_i=0 mid-stream, full range -> next output 225.
  - rst_ni=0 during SEARCH -> all outputs 0, state IDLE at the next edge.
